// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU shifter front end.
//   - ALU_* : 4-bit alu_op_select codes understood by the shifter subunit.
//   - F3_*  : RISC-V funct3 values of the shift instructions.
//   - shift_payload_t : one issued shifter operation (opd1, opd2, op, illegal).
// The payload struct is sized by XLEN; a stage that uses it must be built
// with OPD_LENGTH equal to XLEN.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ILLEGAL = 4'b0000;
    localparam logic [3:0] ALU_SRL     = 4'b0001;
    localparam logic [3:0] ALU_SLL     = 4'b0011;
    localparam logic [3:0] ALU_SRA     = 4'b0111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] opd1;
        logic [XLEN-1:0] opd2;
        logic [3:0]      op;
        logic            illegal;
    } shift_payload_t;

endpackage

// File: rtl/shift_decode.sv
// shift_decode: purely combinational decode of RISC-V shift instruction
// fields (SLL/SRL/SRA, SLLI/SRLI/SRAI) into a shifter payload.
// Ports:
//   funct3, funct7_5, is_imm : instruction form / function selection
//   rs1_val, rs2_val, imm    : operand sources
//   payload                  : opd1, zero-extended shift amount, op code,
//                              illegal flag
module shift_decode
    import alu_pkg::*;
#(
    parameter int OPD_LENGTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  is_imm,
    input  logic [OPD_LENGTH-1:0] rs1_val,
    input  logic [OPD_LENGTH-1:0] rs2_val,
    input  logic [11:0]           imm,
    output shift_payload_t        payload
);

    logic                   fbit;
    logic                   imm_ok;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [3:0]             op;
    logic                   illegal;

    // Upper rs2 bits never contribute to the shift amount.
    logic unused_rs2_bits;
    assign unused_rs2_bits = ^rs2_val[OPD_LENGTH-1:SHAMT_WIDTH];

    always_comb begin
        // Immediate form carries the arithmetic flag in imm[10] (funct7 bit 5).
        fbit   = is_imm ? imm[10] : funct7_5;
        shamt  = is_imm ? imm[SHAMT_WIDTH-1:0] : rs2_val[SHAMT_WIDTH-1:0];
        imm_ok = !is_imm || (imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b0100000);

        op = ALU_ILLEGAL;
        unique case (funct3)
            F3_SLL:  op = ALU_SLL;
            F3_SR:   op = fbit ? ALU_SRA : ALU_SRL;
            default: op = ALU_ILLEGAL;
        endcase
        if (!imm_ok) begin
            op = ALU_ILLEGAL;
        end
        illegal = (op == ALU_ILLEGAL);

        payload.opd1    = rs1_val;
        // Illegal entries still travel, but never carry a shift amount.
        payload.opd2    = illegal ? '0 : {{(OPD_LENGTH-SHAMT_WIDTH){1'b0}}, shamt};
        payload.op      = op;
        payload.illegal = illegal;
    end

endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: registered issue stage feeding the ALU shifter.
// Decodes shift instruction fields, then holds them in a 2-entry skid buffer
// (main drives the outputs, skid absorbs one entry while main is stalled) so
// that in_ready is a plain register yet throughput is one transfer per cycle.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid / in_ready           : upstream handshake (in_ready registered)
//   in_funct3, in_funct7_5, in_is_imm, in_rs1_val, in_rs2_val, in_imm
//                                 : decoded instruction fields
//   out_valid / out_ready         : shifter-side handshake
//   opd1, opd2, alu_op_select, out_illegal : issued payload
//   issued_cnt, illegal_cnt       : wrapping output-transfer statistics
module shift_issue_stage
    import alu_pkg::*;
#(
    parameter int OPD_LENGTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic                  in_is_imm,
    input  logic [OPD_LENGTH-1:0] in_rs1_val,
    input  logic [OPD_LENGTH-1:0] in_rs2_val,
    input  logic [11:0]           in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPD_LENGTH-1:0] opd1,
    output logic [OPD_LENGTH-1:0] opd2,
    output logic [3:0]            alu_op_select,
    output logic                  out_illegal,
    output logic [CNT_WIDTH-1:0]  issued_cnt,
    output logic [CNT_WIDTH-1:0]  illegal_cnt
);

    shift_payload_t dec_payload;

    shift_payload_t main_reg, main_next;
    shift_payload_t skid_reg, skid_next;
    logic           main_valid_reg, main_valid_next;
    logic           skid_valid_reg, skid_valid_next;
    logic           in_ready_reg, in_ready_next;
    logic [CNT_WIDTH-1:0] issued_cnt_reg, issued_cnt_next;
    logic [CNT_WIDTH-1:0] illegal_cnt_reg, illegal_cnt_next;

    logic in_fire;
    logic out_fire;

    shift_decode #(
        .OPD_LENGTH  (OPD_LENGTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_decode (
        .funct3   (in_funct3),
        .funct7_5 (in_funct7_5),
        .is_imm   (in_is_imm),
        .rs1_val  (in_rs1_val),
        .rs2_val  (in_rs2_val),
        .imm      (in_imm),
        .payload  (dec_payload)
    );

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = main_valid_reg && out_ready;

    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;

        if (!main_valid_reg || out_fire) begin
            // Main is free this cycle. A waiting skid entry is older than
            // anything on the input, so it goes first; in_ready was low
            // while skid was full, so no input can arrive in the same cycle.
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                main_next       = dec_payload;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            // Main stalled: park the new entry in skid.
            skid_next       = dec_payload;
            skid_valid_next = 1'b1;
        end

        in_ready_next = !skid_valid_next;

        issued_cnt_next  = issued_cnt_reg;
        illegal_cnt_next = illegal_cnt_reg;
        if (out_fire) begin
            issued_cnt_next = issued_cnt_reg + 1'b1;
            if (main_reg.illegal) begin
                illegal_cnt_next = illegal_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg        <= '0;
            skid_reg        <= '0;
            main_valid_reg  <= 1'b0;
            skid_valid_reg  <= 1'b0;
            in_ready_reg    <= 1'b0;
            issued_cnt_reg  <= '0;
            illegal_cnt_reg <= '0;
        end else begin
            main_reg        <= main_next;
            skid_reg        <= skid_next;
            main_valid_reg  <= main_valid_next;
            skid_valid_reg  <= skid_valid_next;
            in_ready_reg    <= in_ready_next;
            issued_cnt_reg  <= issued_cnt_next;
            illegal_cnt_reg <= illegal_cnt_next;
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = main_valid_reg;
    assign opd1          = main_reg.opd1;
    assign opd2          = main_reg.opd2;
    assign alu_op_select = main_reg.op;
    assign out_illegal   = main_reg.illegal;
    assign issued_cnt    = issued_cnt_reg;
    assign illegal_cnt   = illegal_cnt_reg;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: directed self-checking bench for shift_issue_stage.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. well away from the active edge.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        in_is_imm;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opd1;
    logic [31:0] opd2;
    logic [3:0]  alu_op_select;
    logic        out_illegal;
    logic [15:0] issued_cnt;
    logic [15:0] illegal_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    shift_issue_stage #(
        .OPD_LENGTH  (32),
        .SHAMT_WIDTH (5),
        .CNT_WIDTH   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_funct3     (in_funct3),
        .in_funct7_5   (in_funct7_5),
        .in_is_imm     (in_is_imm),
        .in_rs1_val    (in_rs1_val),
        .in_rs2_val    (in_rs2_val),
        .in_imm        (in_imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .opd1          (opd1),
        .opd2          (opd2),
        .alu_op_select (alu_op_select),
        .out_illegal   (out_illegal),
        .issued_cnt    (issued_cnt),
        .illegal_cnt   (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic f7, input logic imm_form,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [11:0] imm);
        in_valid    = 1'b1;
        in_funct3   = f3;
        in_funct7_5 = f7;
        in_is_imm   = imm_form;
        in_rs1_val  = rs1;
        in_rs2_val  = rs2;
        in_imm      = imm;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({out_valid, in_ready, out_illegal} !== 3'b000) $display("FAIL reset_ctrl got=%b want=000", {out_valid, in_ready, out_illegal});
        else pass_cnt++;
        total_cnt++;
        if ({opd1, opd2, alu_op_select} !== 68'd0) $display("FAIL reset_payload got=%h/%h/%b want=0", opd1, opd2, alu_op_select);
        else pass_cnt++;
        total_cnt++;
        if ({issued_cnt, illegal_cnt} !== 32'd0) $display("FAIL reset_cnt got=%h/%h want=0/0", issued_cnt, illegal_cnt);
        else pass_cnt++;
        #3 rst = 1'b0;
        step();
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", in_ready);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_srl();
        out_ready = 1'b1;
        drive(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0024, 12'h000);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, alu_op_select} !== 5'b1_0001) $display("FAIL srl_op got=%b/%b want=1/0001", out_valid, alu_op_select);
        else pass_cnt++;
        total_cnt++;
        if (opd2 !== 32'h4 || opd1 !== 32'h8000_0000) $display("FAIL srl_opd got=%h/%h want=80000000/00000004", opd1, opd2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (issued_cnt !== 16'd1 || out_valid !== 1'b0) $display("FAIL srl_issued got=%0d/%b want=1/0", issued_cnt, out_valid);
        else pass_cnt++;
        $display("test_srl done");
    endtask

    task automatic test_srai();
        drive(3'b101, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_001F, 12'h405);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({alu_op_select, out_illegal} !== 5'b0111_0) $display("FAIL srai_op got=%b/%b want=0111/0", alu_op_select, out_illegal);
        else pass_cnt++;
        total_cnt++;
        if (opd2 !== 32'd5 || opd1 !== 32'hF000_0000) $display("FAIL srai_opd got=%h/%h want=f0000000/00000005", opd1, opd2);
        else pass_cnt++;
        step();
        $display("test_srai done");
    endtask

    task automatic test_illegal();
        // SLLI with imm[9] set: imm[11:5]=0010001 is not a legal encoding.
        drive(3'b001, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 12'h225);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_illegal, alu_op_select} !== 6'b11_0000) $display("FAIL slli_bad_op got=%b/%b/%b want=1/1/0000", out_valid, out_illegal, alu_op_select);
        else pass_cnt++;
        total_cnt++;
        if (opd2 !== 32'd0 || opd1 !== 32'h1234_5678) $display("FAIL slli_bad_opd got=%h/%h want=12345678/00000000", opd1, opd2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (illegal_cnt !== 16'd1) $display("FAIL slli_bad_cnt got=%0d want=1", illegal_cnt);
        else pass_cnt++;
        // Register form with an unused funct3 is also illegal.
        drive(3'b000, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h3, 12'h000);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_illegal, alu_op_select, opd2} !== {1'b1, 4'b0000, 32'd0}) $display("FAIL f3_bad got=%b/%b/%h want=1/0000/0", out_illegal, alu_op_select, opd2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (illegal_cnt !== 16'd2 || issued_cnt !== 16'd4) $display("FAIL f3_bad_cnt got=%0d/%0d want=2/4", illegal_cnt, issued_cnt);
        else pass_cnt++;
        $display("test_illegal done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(3'b001, 1'b0, 1'b0, 32'h1, 32'h3, 12'h000);          // SLL
        step();                                                      // accepted into main
        total_cnt++;
        if ({in_ready, out_valid, alu_op_select} !== 6'b11_0011) $display("FAIL b2b_first got=%b/%b/%b want=1/1/0011", in_ready, out_valid, alu_op_select);
        else pass_cnt++;
        drive(3'b101, 1'b0, 1'b0, 32'h2, 32'h7, 12'h000);          // SRL
        step();                                                      // accepted into skid
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_ready_fall got=%b want=0", in_ready);
        else pass_cnt++;
        drive(3'b101, 1'b1, 1'b0, 32'h3, 32'h9, 12'h000);          // SRA, held off
        step();
        total_cnt++;
        if ({in_ready, alu_op_select, opd2} !== {1'b0, 4'b0011, 32'd3}) $display("FAIL b2b_stall got=%b/%b/%h want=0/0011/3", in_ready, alu_op_select, opd2);
        else pass_cnt++;
        out_ready = 1'b1;
        step();                                                      // SLL out, skid->main
        total_cnt++;
        if ({in_ready, alu_op_select, opd2} !== {1'b1, 4'b0001, 32'd7}) $display("FAIL b2b_second got=%b/%b/%h want=1/0001/7", in_ready, alu_op_select, opd2);
        else pass_cnt++;
        step();                                                      // SRL out, SRA in
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, alu_op_select, opd2} !== {1'b1, 4'b0111, 32'd9}) $display("FAIL b2b_third got=%b/%b/%h want=1/0111/9", out_valid, alu_op_select, opd2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || issued_cnt !== 16'd7) $display("FAIL b2b_drain got=%b/%0d want=0/7", out_valid, issued_cnt);
        else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(3'b001, 1'b0, 1'b0, 32'h11, 32'h1, 12'h000);
        step();
        drive(3'b001, 1'b0, 1'b0, 32'h22, 32'h2, 12'h000);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b10) $display("FAIL areset_full got=%b/%b want=1/0", out_valid, in_ready);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b00) $display("FAIL areset_now got=%b/%b want=0/0", out_valid, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
        step();
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10 || {issued_cnt, illegal_cnt} !== 32'd0) $display("FAIL areset_release got=%b/%b/%0d/%0d want=1/0/0/0", in_ready, out_valid, issued_cnt, illegal_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0 || issued_cnt !== 16'd0) $display("FAIL areset_no_replay got=%b/%0d want=0/0", out_valid, issued_cnt);
        else pass_cnt++;
        $display("test_async_reset done");
    endtask

    task automatic test_counter_wrap();
        out_ready = 1'b1;
        drive(3'b001, 1'b0, 1'b0, 32'h5, 32'h1, 12'h000);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (issued_cnt !== 16'hFFFF || illegal_cnt !== 16'd0) $display("FAIL wrap_pre got=%h/%h want=ffff/0000", issued_cnt, illegal_cnt);
        else pass_cnt++;
        drive(3'b001, 1'b0, 1'b0, 32'h6, 32'h2, 12'h000);
        step();
        in_valid = 1'b0;
        step();
        total_cnt++;
        if (issued_cnt !== 16'h0000 || out_valid !== 1'b0) $display("FAIL wrap_post got=%h/%b want=0000/0", issued_cnt, out_valid);
        else pass_cnt++;
        $display("test_counter_wrap done");
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_funct3   = 3'b000;
        in_funct7_5 = 1'b0;
        in_is_imm   = 1'b0;
        in_rs1_val  = 32'h0;
        in_rs2_val  = 32'h0;
        in_imm      = 12'h000;
        out_ready   = 1'b0;
        step();
        step();
        test_reset();
        test_srl();
        test_srai();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered issue stage directly upstream of the ALU shifter subunit.
- Accepts decoded RISC-V shift-instruction fields (SLL/SRL/SRA and SLLI/SRLI/SRAI) over a valid/ready handshake.
- Produces the shifter's operand pair and its 4-bit alu_op_select code, with opd2 already reduced to a legal shift amount.
- A 2-entry skid buffer gives full throughput while fully registering in_ready.

Parameters:
- OPD_LENGTH, 32, operand width in bits.
- SHAMT_WIDTH, 5, shift-amount width in bits; must equal log2(OPD_LENGTH).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  upstream holds valid instruction fields.
- in_ready  output  1  stage can accept; registered.
- in_funct3  input  3  instruction funct3.
- in_funct7_5  input  1  funct7 bit 5, register form only.
- in_is_imm  input  1  1 = immediate form (SLLI/SRLI/SRAI).
- in_rs1_val  input  OPD_LENGTH  rs1 operand value.
- in_rs2_val  input  OPD_LENGTH  rs2 operand value, register form.
- in_imm  input  12  I-type immediate, immediate form.
- out_valid  output  1  output payload valid.
- out_ready  input  1  shifter side accepts the payload.
- opd1  output  OPD_LENGTH  to shifter opd1.
- opd2  output  OPD_LENGTH  to shifter opd2; zero-extended shift amount.
- alu_op_select  output  4  0001 SRL, 0011 SLL, 0111 SRA, 0000 illegal.
- out_illegal  output  1  payload carries an undecodable instruction.
- issued_cnt  output  CNT_WIDTH  count of accepted output transfers.
- illegal_cnt  output  CNT_WIDTH  count of illegal output transfers.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers clear, so out_valid=0, opd1=0, opd2=0, alu_op_select=0000, out_illegal=0, and both counters are 0.
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
  - Reset asserted mid-transfer discards all buffered entries; nothing is replayed.
- Decode (combinational on input, registered at capture):
  - funct3=001 gives SLL.
  - funct3=101 with fbit=0 gives SRL; with fbit=1 gives SRA.
  - fbit is in_funct7_5 in register form and in_imm[10] in immediate form.
  - Immediate form is illegal unless in_imm[11:5] is 0000000 or 0100000.
  - Any other funct3 is illegal.
- Shift amount:
  - Register form uses in_rs2_val[SHAMT_WIDTH-1:0].
  - Immediate form uses in_imm[SHAMT_WIDTH-1:0].
  - The amount is zero-extended to OPD_LENGTH.
- Illegal entries:
  - Still transferred, with alu_op_select=0000, opd2=0, opd1=in_rs1_val and out_illegal=1.
  - They are never dropped silently.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
  - The output payload is stable while out_valid && !out_ready.
- Skid buffer:
  - Two entries: main (drives outputs) and skid.
  - in_ready = !skid_valid, registered.
  - Input transfer with main empty, or main draining this cycle: the entry loads into main.
  - Input transfer while main is stalled: the entry loads into skid, and in_ready drops the next cycle.
  - When main drains with skid full: skid moves to main and in_ready rises the next cycle.
  - Simultaneous drain and input transfer with skid empty: the new entry goes to main.
- Timing:
  - Latency from input transfer to out_valid is 1 cycle.
  - Sustained throughput is 1 transfer per cycle when out_ready is held 1.
  - Ordering is strictly FIFO.
- Counters:
  - issued_cnt increments on each output transfer.
  - illegal_cnt increments on each output transfer with out_illegal=1.
  - Both wrap modulo 2^CNT_WIDTH without saturation.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants ALU_SRL=4'b0001, ALU_SLL=4'b0011, ALU_SRA=4'b0111 and ALU_ILLEGAL=4'b0000.
  - Funct3 constants F3_SLL=3'b001 and F3_SR=3'b101.
  - The payload struct: opd1, opd2, op and illegal.
- Natural sub-module: shift_decode, purely combinational: fields to payload.
- The skid buffer and counters stay in the top module.

Test Plan:
- Register SRL, rs1=0x8000_0000, rs2=0x0000_0024, out_ready=1 -> one cycle later: out_valid=1, alu_op_select=0001, opd2=0x4, issued_cnt=1.
- SRAI, imm=0x405, rs1=0xF000_0000 -> alu_op_select=0111, opd2=5, out_illegal=0.
- SLLI with imm=0x225 (bit 9 set) -> out_illegal=1, alu_op_select=0000, opd2=0, illegal_cnt=1.
- Back-to-back SLL, SRL, SRA with out_ready=0 for 3 cycles:
  - in_ready falls one cycle after the second acceptance.
  - The third instruction is held off until the stall clears.
  - Once out_ready=1, outputs appear in order 0011, 0001, 0111 with no loss or duplication.
- Assert rst asynchronously with both entries full -> out_valid=0 and in_ready=0 immediately; after release in_ready=1 and both counters are 0.
- Preload issued_cnt at 0xFFFF via 65535 transfers, then one more -> issued_cnt wraps to 0x0000.
